seq_alu: RTL and testbench

Parametrised, registered successor to the team's single-cycle combinational ALU for the multicycle MIPS datapath. It keeps the logic, add/sub and compare operations and adds signed overflow, unsigned set-less-than, and an iterative unsigned multiply/divide engine with a HI result register. A start/ready/done handshake lets the multicycle controller stall on long operations.

---
 rtl/seq_alu_pkg.sv | 34 +++
 rtl/seq_alu_if.sv | 36 +++
 rtl/seq_alu_muldiv_iter.sv | 168 ++++++++++++++++
 rtl/seq_alu.sv | 207 ++++++++++++++++++++
 tb/tb_seq_alu.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
// -----------------------------------------------------------------------------
// seq_alu_pkg
// Shared definitions for the sequential ALU: opcode encodings, the
// controller state type and the decode of multi-cycle opcodes.
// Build option: SEQ_ALU_DIV_EN -- when defined, DIVU is a multi-cycle op;
// otherwise 1010 falls through to the invalid-opcode path.
// -----------------------------------------------------------------------------
package seq_alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1010;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // True for opcodes that run on the iterative multiply/divide engine.
  function automatic logic is_long_op(input logic [3:0] f);
    logic long_v;
    long_v = (f == OP_MULU);
`ifdef SEQ_ALU_DIV_EN
    long_v = long_v || (f == OP_DIVU);
`endif
    return long_v;
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// -----------------------------------------------------------------------------
// seq_alu_if
// Request/result bundle between the multicycle controller (master) and the
// sequential ALU (slave).
//   start, F, A, B            : request, sampled by the ALU while ready=1
//   ready                     : ALU idle, a start will be accepted
//   done                      : one-cycle pulse, results valid from this cycle
//   Y, HI, Zero, Ovf, Dbz     : registered results and flags
// -----------------------------------------------------------------------------
interface seq_alu_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [3:0]       F;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] HI;
  logic             Zero;
  logic             Ovf;
  logic             Dbz;

  modport master (
    output start, F, A, B,
    input  ready, done, Y, HI, Zero, Ovf, Dbz
  );

  modport slave (
    input  start, F, A, B,
    output ready, done, Y, HI, Zero, Ovf, Dbz
  );

endinterface

// File: rtl/seq_alu_muldiv_iter.sv
// -----------------------------------------------------------------------------
// muldiv_iter
// Iterative unsigned multiply (shift-add) and restoring divide engine sharing
// one {hi,lo} shift register, one WIDTH-bit adder/subtractor and a counter.
//   clk, reset_n : clock, asynchronous active-low reset (aborts any run)
//   go           : load a, b, op and start a WIDTH-step run
//   op           : 1 = DIVU, 0 = MULU (sampled with go)
//   a, b         : multiplicand/multiplier or dividend/divisor
//   lo, hi       : value the shift register takes at the next step; on the
//                  edge where fin=1 this is the final product/quotient pair
//   dbz          : divisor of the current run was zero
//   fin          : the upcoming edge performs the last step
// Build option: SEQ_ALU_DIV_EN -- compiles in the division step and dbz.
// -----------------------------------------------------------------------------
module muldiv_iter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             dbz,
  output logic             fin
);

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] mul_hi_s, mul_lo_s;
  logic [WIDTH-1:0] hi_step_s, lo_step_s;

  // Shift-add multiply step: add b into hi when the current multiplier bit
  // (lo[0]) is set, then shift the WIDTH+1-bit sum and lo right by one.
  always_comb begin
    if (lo_q[0]) begin
      sum_s = {1'b0, hi_q} + {1'b0, b_q};
    end else begin
      sum_s = {1'b0, hi_q};
    end
    mul_hi_s = sum_s[WIDTH:1];
    mul_lo_s = {sum_s[0], lo_q[WIDTH-1:1]};
  end

`ifdef SEQ_ALU_DIV_EN
  logic             div_q, div_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH-1:0] trial_s;
  logic [WIDTH-1:0] div_hi_s, div_lo_s;

  // Restoring divide step: shift the next dividend bit into the remainder,
  // subtract the divisor when it fits and shift the quotient bit into lo.
  // A zero divisor always "fits", giving an all-ones quotient and HI = A.
  always_comb begin
    rem_sh_s = {hi_q, lo_q[WIDTH-1]};
    trial_s  = rem_sh_s[WIDTH-1:0] - b_q;
    if (rem_sh_s >= {1'b0, b_q}) begin
      div_hi_s = trial_s;
      div_lo_s = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      div_hi_s = rem_sh_s[WIDTH-1:0];
      div_lo_s = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  // Select which engine step drives the shift register.
  always_comb begin
    if (div_q) begin
      hi_step_s = div_hi_s;
      lo_step_s = div_lo_s;
    end else begin
      hi_step_s = mul_hi_s;
      lo_step_s = mul_lo_s;
    end
  end

  // Next state of the divide-only bookkeeping.
  always_comb begin
    div_d = div_q;
    dbz_d = dbz_q;
    if (go) begin
      div_d = op;
      dbz_d = (b == {WIDTH{1'b0}});
    end else begin
      div_d = div_q;
      dbz_d = dbz_q;
    end
  end

  // Divide-only registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      div_q <= div_d;
      dbz_q <= dbz_d;
    end
  end

  assign dbz = dbz_q;
`else
  logic unused_op_s;

  // Only the multiply step exists in this build.
  always_comb begin
    hi_step_s = mul_hi_s;
    lo_step_s = mul_lo_s;
  end

  assign unused_op_s = op;
  assign dbz         = 1'b0;
`endif

  // Load on go, otherwise step while the counter is non-zero.
  always_comb begin
    cnt_d = cnt_q;
    lo_d  = lo_q;
    hi_d  = hi_q;
    b_d   = b_q;
    if (go) begin
      cnt_d = CNT_LOAD;
      lo_d  = a;
      hi_d  = {WIDTH{1'b0}};
      b_d   = b;
    end else if (cnt_q != CNT_ZERO) begin
      cnt_d = cnt_q - CNT_ONE;
      lo_d  = lo_step_s;
      hi_d  = hi_step_s;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Shift register, operand and counter state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= CNT_ZERO;
      lo_q  <= {WIDTH{1'b0}};
      hi_q  <= {WIDTH{1'b0}};
      b_q   <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
      lo_q  <= lo_d;
      hi_q  <= hi_d;
      b_q   <= b_d;
    end
  end

  assign lo  = lo_step_s;
  assign hi  = hi_step_s;
  assign fin = (cnt_q == CNT_ONE);

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Registered ALU for the multicycle MIPS datapath. Single-cycle ops (AND, OR,
// ADD, SUB, SLT, SLTU) complete on the accepting edge; MULU/DIVU run WIDTH
// steps on muldiv_iter while ready is low.
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset; aborts a running operation
//   bus     : seq_alu_if slave (start/F/A/B in; ready/done/Y/HI/flags out)
// Build option: SEQ_ALU_DIV_EN -- enables DIVU and the Dbz flag; without it
// 1010 is an invalid opcode and Dbz stays 0.
// -----------------------------------------------------------------------------
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic        clk,
  input  logic        reset_n,
  seq_alu_if.slave    bus
);

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] sum_s, diff_s, res_s;
  logic             ovf_add_s, ovf_sub_s, res_ovf_s;
  logic             long_s, go_s, op_div_s;
  logic [WIDTH-1:0] md_lo_s, md_hi_s;
  logic             md_dbz_s, md_fin_s;

  assign long_s   = is_long_op(bus.F);
  assign op_div_s = (bus.F == OP_DIVU);

  muldiv_iter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_muldiv (
    .clk     (clk),
    .reset_n (reset_n),
    .go      (go_s),
    .op      (op_div_s),
    .a       (bus.A),
    .b       (bus.B),
    .lo      (md_lo_s),
    .hi      (md_hi_s),
    .dbz     (md_dbz_s),
    .fin     (md_fin_s)
  );

  // Single-cycle datapath. Signed overflow: operands of equal sign for ADD
  // (opposite sign for SUB) producing a result whose sign differs from A.
  always_comb begin
    sum_s     = bus.A + bus.B;
    diff_s    = bus.A - bus.B;
    ovf_add_s = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum_s[WIDTH-1] != bus.A[WIDTH-1]);
    ovf_sub_s = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (diff_s[WIDTH-1] != bus.A[WIDTH-1]);
    res_ovf_s = 1'b0;
    case (bus.F)
      OP_AND:  res_s = bus.A & bus.B;
      OP_OR:   res_s = bus.A | bus.B;
      OP_ADD: begin
        res_s     = sum_s;
        res_ovf_s = ovf_add_s;
      end
      OP_SUB: begin
        res_s     = diff_s;
        res_ovf_s = ovf_sub_s;
      end
      OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, diff_s[WIDTH-1] ^ ovf_sub_s};
      OP_SLTU: res_s = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      default: res_s = ZERO_W;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: long ops park in BUSY until the engine's last step.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start && long_s) begin
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (md_fin_s) begin
          state_d = IDLE;
        end else begin
          state_d = BUSY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: next values of the result registers and the engine launch.
  always_comb begin
    y_d    = y_q;
    hi_d   = hi_q;
    zero_d = zero_q;
    ovf_d  = ovf_q;
    dbz_d  = dbz_q;
    done_d = 1'b0;
    go_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && long_s) begin
          go_s = 1'b1;
        end else if (bus.start) begin
          done_d = 1'b1;
          y_d    = res_s;
          zero_d = (res_s == ZERO_W);
          ovf_d  = res_ovf_s;
        end else begin
          done_d = 1'b0;
        end
      end
      BUSY: begin
        if (md_fin_s) begin
          done_d = 1'b1;
          y_d    = md_lo_s;
          hi_d   = md_hi_s;
          zero_d = (md_lo_s == ZERO_W);
          ovf_d  = 1'b0;
          dbz_d  = dbz_from_engine(dbz_q);
        end else begin
          done_d = 1'b0;
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
  end

`ifdef SEQ_ALU_DIV_EN
  logic div_run_q;

  // Remembers whether the running long op is a DIVU so Dbz only moves then.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_run_q <= 1'b0;
    end else if (go_s) begin
      div_run_q <= op_div_s;
    end else begin
      div_run_q <= div_run_q;
    end
  end

  function automatic logic dbz_from_engine(input logic cur);
    return div_run_q ? md_dbz_s : cur;
  endfunction
`else
  logic unused_dbz_s;
  assign unused_dbz_s = md_dbz_s;

  function automatic logic dbz_from_engine(input logic cur);
    return cur;
  endfunction
`endif

  // Result and flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y_q    <= ZERO_W;
      hi_q   <= ZERO_W;
      zero_q <= 1'b1;
      ovf_q  <= 1'b0;
      dbz_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      y_q    <= y_d;
      hi_q   <= hi_d;
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
      dbz_q  <= dbz_d;
      done_q <= done_d;
    end
  end

  assign bus.ready = (state_q == IDLE);
  assign bus.done  = done_q;
  assign bus.Y     = y_q;
  assign bus.HI    = hi_q;
  assign bus.Zero  = zero_q;
  assign bus.Ovf   = ovf_q;
  assign bus.Dbz   = dbz_q;

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
// Directed self-checking bench for seq_alu (WIDTH=32). Latency is measured as
// the number of rising edges after the accepting edge until done is seen:
// 0 for single-cycle ops, 32 for MULU/DIVU. Outputs are sampled on the
// falling edge. DIVU expectations follow the SEQ_ALU_DIV_EN build option.
// -----------------------------------------------------------------------------
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n;
  int   tests = 0;
  int   fails = 0;
  int   lat;
  int   seen;
  logic ready_mid;

  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Issue one request; optionally pulse a stray start (and disturb A/B)
  // while the operation is running. lat_o = -1 if done never appears.
  task automatic run_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                        input bit inject, output int lat_o);
    @(negedge clk);
    bus.start = 1'b1;
    bus.F = f;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat_o = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (bus.done) begin
        lat_o = n;
        break;
      end
      if (inject && n == 3) begin
        ready_mid = bus.ready;
        bus.start = 1'b1;
        bus.F = OP_ADD;
        bus.A = 32'h0000_0001;
        bus.B = 32'h0000_0001;
      end
      if (inject && n == 4) begin
        bus.start = 1'b0;
        bus.A = 32'h0000_0000;
        bus.B = 32'h0000_0000;
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.F = 4'b0000;
    bus.A = 32'h0;
    bus.B = 32'h0;
    ready_mid = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_Y", bus.Y, 32'h0);
    check("rst_HI", bus.HI, 32'h0);
    check("rst_Zero", {31'b0, bus.Zero}, 32'd1);
    check("rst_Ovf", {31'b0, bus.Ovf}, 32'd0);
    check("rst_Dbz", {31'b0, bus.Dbz}, 32'd0);
    check("rst_ready", {31'b0, bus.ready}, 32'd1);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    reset_n = 1'b1;

    run_op(OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat);
    check("add_lat", 32'(lat), 32'd0);
    check("add_Y", bus.Y, 32'h8000_0000);
    check("add_Ovf", {31'b0, bus.Ovf}, 32'd1);
    check("add_Zero", {31'b0, bus.Zero}, 32'd0);
    check("add_ready", {31'b0, bus.ready}, 32'd1);
    @(negedge clk);
    check("add_done_pulse", {31'b0, bus.done}, 32'd0);
    check("add_Y_hold", bus.Y, 32'h8000_0000);

    run_op(4'b0011, 32'h0000_1234, 32'h0000_5678, 1'b0, lat);
    check("inv_lat", 32'(lat), 32'd0);
    check("inv_Y", bus.Y, 32'h0);
    check("inv_Zero", {31'b0, bus.Zero}, 32'd1);
    check("inv_Ovf", {31'b0, bus.Ovf}, 32'd0);

    run_op(OP_SUB, 32'd5, 32'd5, 1'b0, lat);
    check("sub_Y", bus.Y, 32'h0);
    check("sub_Zero", {31'b0, bus.Zero}, 32'd1);
    run_op(OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, lat);
    check("subovf_Y", bus.Y, 32'h7FFF_FFFF);
    check("subovf_Ovf", {31'b0, bus.Ovf}, 32'd1);
    run_op(OP_SLT, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
    check("slt_Y", bus.Y, 32'd1);
    check("slt_Ovf", {31'b0, bus.Ovf}, 32'd0);
    run_op(OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat);
    check("sltu_Y", bus.Y, 32'd0);
    check("sltu_Zero", {31'b0, bus.Zero}, 32'd1);
    run_op(OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, lat);
    check("and_Y", bus.Y, 32'h0000_F000);
    run_op(OP_OR, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, lat);
    check("or_Y", bus.Y, 32'h0000_FFF0);

    run_op(OP_MULU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat);
    check("mul_lat", 32'(lat), 32'd32);
    check("mul_Y", bus.Y, 32'h0000_0001);
    check("mul_HI", bus.HI, 32'hFFFF_FFFE);
    check("mul_Zero", {31'b0, bus.Zero}, 32'd0);
    check("mul_ready_busy", {31'b0, ready_mid}, 32'd0);
    check("mul_ready_done", {31'b0, bus.ready}, 32'd1);
    @(negedge clk);
    check("mul_no_queue", {31'b0, bus.done}, 32'd0);
    check("mul_Y_hold", bus.Y, 32'h0000_0001);

    run_op(OP_ADD, 32'd2, 32'd3, 1'b0, lat);
    check("add_hi_keep_Y", bus.Y, 32'd5);
    check("add_hi_keep_HI", bus.HI, 32'hFFFF_FFFE);

`ifdef SEQ_ALU_DIV_EN
    run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, lat);
    check("div_lat", 32'(lat), 32'd32);
    check("div_Y", bus.Y, 32'd14);
    check("div_HI", bus.HI, 32'd2);
    check("div_Dbz", {31'b0, bus.Dbz}, 32'd0);
    run_op(OP_DIVU, 32'd9, 32'd0, 1'b0, lat);
    check("dbz_lat", 32'(lat), 32'd32);
    check("dbz_Y", bus.Y, 32'hFFFF_FFFF);
    check("dbz_HI", bus.HI, 32'd9);
    check("dbz_Dbz", {31'b0, bus.Dbz}, 32'd1);
`else
    run_op(OP_DIVU, 32'd100, 32'd7, 1'b0, lat);
    check("nodiv_lat", 32'(lat), 32'd0);
    check("nodiv_Y", bus.Y, 32'h0);
    check("nodiv_Zero", {31'b0, bus.Zero}, 32'd1);
    check("nodiv_HI", bus.HI, 32'hFFFF_FFFE);
    check("nodiv_Dbz", {31'b0, bus.Dbz}, 32'd0);
`endif

    run_op(OP_MULU, 32'd6, 32'd7, 1'b0, lat);
    check("mul2_lat", 32'(lat), 32'd32);
    check("mul2_Y", bus.Y, 32'd42);
    check("mul2_HI", bus.HI, 32'h0);
`ifdef SEQ_ALU_DIV_EN
    check("mul2_Dbz_keep", {31'b0, bus.Dbz}, 32'd1);
`else
    check("mul2_Dbz_keep", {31'b0, bus.Dbz}, 32'd0);
`endif

    // Abort a MULU with reset 10 cycles in.
    @(negedge clk);
    bus.start = 1'b1;
    bus.F = OP_MULU;
    bus.A = 32'h1234_5678;
    bus.B = 32'h0000_0010;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_ready", {31'b0, bus.ready}, 32'd1);
    check("abort_done", {31'b0, bus.done}, 32'd0);
    check("abort_Y", bus.Y, 32'h0);
    check("abort_HI", bus.HI, 32'h0);
    check("abort_Zero", {31'b0, bus.Zero}, 32'd1);
    check("abort_Ovf", {31'b0, bus.Ovf}, 32'd0);
    check("abort_Dbz", {31'b0, bus.Dbz}, 32'd0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    reset_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);

    run_op(OP_ADD, 32'd2, 32'd3, 1'b0, lat);
    check("post_abort_lat", 32'(lat), 32'd0);
    check("post_abort_Y", bus.Y, 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
